fc_layer_seq: RTL and testbench

Parametrised, sequential fully-connected layer computing N_OUT neurons over an N_IN-element signed input vector with one multiply-accumulate (MAC) per clock. Each neuron result is biased, saturated to OUT_W and optionally ReLU-clipped. Weights and biases sit in on-chip registers loaded through a config write port. The block sits after the convolution/pooling stages in each accelerator core and replaces the single-neuron, single-cycle FC stage with a start/done handshaked unit.

---
 rtl/fc_layer_seq.sv | 211 +++++++++++++++++++++
 tb/tb_fc_layer_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_layer_seq.sv
// rtl/fc_layer_seq.sv - sequential fully-connected layer, one MAC per clock
//
// Computes N_OUT neurons over an N_IN-element signed input vector. Each
// neuron is accumulated one product per clock, then biased, saturated to
// OUT_W and optionally ReLU-clipped. Weights and biases live in local
// registers written through the cfg port while the block is idle.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset, overrides everything
//   start     begin a run (only looked at in IDLE)
//   in_vec    N_IN signed elements, element i at [i*IN_W +: IN_W]
//   cfg_we    config write strobe (dropped while busy)
//   cfg_sel   0 = weight write, 1 = bias write
//   cfg_addr  weight index j*N_IN+i or bias index j
//   cfg_data  weight in [W_W-1:0], bias in all bits
//   busy      high from the accepted start until done
//   done      one-cycle pulse when out_vec is complete
//   out_vec   N_OUT signed results, neuron j at [j*OUT_W +: OUT_W]

module fc_layer_seq #(
    parameter int N_IN  = 9,
    parameter int N_OUT = 4,
    parameter int IN_W  = 8,
    parameter int W_W   = 8,
    parameter int B_W   = 16,
    parameter int ACC_W = 24,
    parameter int OUT_W = 16,
    parameter int RELU  = 0,
    localparam int CFG_AW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N_IN*IN_W-1:0]     in_vec,
    input  logic                     cfg_we,
    input  logic                     cfg_sel,
    input  logic [CFG_AW-1:0]        cfg_addr,
    input  logic [B_W-1:0]           cfg_data,
    output logic                     busy,
    output logic                     done,
    output logic [N_OUT*OUT_W-1:0]   out_vec
);

    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    // Bias sum is formed wide enough that neither the addition nor the
    // saturation compare can wrap.
    localparam int RW = (ACC_W + 1 > OUT_W + 1) ? ACC_W + 1 : OUT_W + 1;

    localparam logic [IW-1:0]       I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0]       J_LAST = JW'(N_OUT - 1);
    localparam logic [CFG_AW:0]     W_CNT  = (CFG_AW + 1)'(N_IN * N_OUT);
    localparam logic [CFG_AW:0]     B_CNT  = (CFG_AW + 1)'(N_OUT);
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_FIN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [W_W-1:0]    w_mem [N_IN*N_OUT];
    logic signed [B_W-1:0]    b_mem [N_OUT];

    logic [N_IN*IN_W-1:0]     in_lat;
    logic signed [ACC_W-1:0]  acc;
    logic [IW-1:0]            i_cnt;
    logic [JW-1:0]            j_cnt;
    // Flat weight index; MAC order walks j*N_IN+i sequentially, so a plain
    // counter replaces the multiply.
    logic [CFG_AW-1:0]        w_idx;

    logic                     cfg_w_ok;
    logic                     cfg_b_ok;

    logic signed [IN_W-1:0]       cur_in;
    logic signed [W_W-1:0]        cur_w;
    logic signed [IN_W+W_W-1:0]   prod;
    logic signed [ACC_W-1:0]      prod_ext;
    logic signed [RW-1:0]         res_wide;
    logic signed [OUT_W-1:0]      res;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_MAC;
            S_MAC:  if (i_cnt == I_LAST) state_next = S_FIN;
            S_FIN:  state_next = (j_cnt == J_LAST) ? S_DONE : S_MAC;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // ------------------------------------------------------------------
    // Config write qualification. busy is low in the cycle a start is
    // accepted, so a same-cycle write lands before the first MAC.
    // ------------------------------------------------------------------
    always_comb begin
        cfg_w_ok = cfg_we && !busy && !cfg_sel && ({1'b0, cfg_addr} < W_CNT);
        cfg_b_ok = cfg_we && !busy &&  cfg_sel && ({1'b0, cfg_addr} < B_CNT);
    end

    // ------------------------------------------------------------------
    // MAC and finish arithmetic
    // ------------------------------------------------------------------
    always_comb begin
        cur_in   = in_lat[i_cnt*IN_W +: IN_W];
        cur_w    = w_mem[w_idx];
        prod     = cur_in * cur_w;
        prod_ext = {{(ACC_W - IN_W - W_W){prod[IN_W+W_W-1]}}, prod};

        res_wide = {{(RW - ACC_W){acc[ACC_W-1]}}, acc}
                 + {{(RW - B_W){b_mem[j_cnt][B_W-1]}}, b_mem[j_cnt]};

        if (res_wide > SAT_MAX) begin
            res = SAT_MAX[OUT_W-1:0];
        end else if (res_wide < SAT_MIN) begin
            res = SAT_MIN[OUT_W-1:0];
        end else begin
            res = res_wide[OUT_W-1:0];
        end

        if ((RELU != 0) && res[OUT_W-1]) begin
            res = '0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and parameter storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_IN * N_OUT; k++) begin
                w_mem[k] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                b_mem[k] <= '0;
            end
            in_lat  <= '0;
            acc     <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            w_idx   <= '0;
            out_vec <= '0;
        end else begin
            if (cfg_w_ok) begin
                w_mem[cfg_addr] <= cfg_data[W_W-1:0];
            end
            if (cfg_b_ok) begin
                b_mem[cfg_addr[JW-1:0]] <= cfg_data;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        in_lat <= in_vec;
                        acc    <= '0;
                        i_cnt  <= '0;
                        j_cnt  <= '0;
                        w_idx  <= '0;
                    end
                end
                S_MAC: begin
                    acc   <= acc + prod_ext;
                    w_idx <= w_idx + CFG_AW'(1);
                    if (i_cnt != I_LAST) begin
                        i_cnt <= i_cnt + IW'(1);
                    end
                end
                S_FIN: begin
                    out_vec[j_cnt*OUT_W +: OUT_W] <= res;
                    acc   <= '0;
                    i_cnt <= '0;
                    if (j_cnt != J_LAST) begin
                        j_cnt <= j_cnt + JW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb/tb_fc_layer_seq.sv - self-checking bench for fc_layer_seq

module tb_fc_layer_seq;

    localparam int N_IN  = 9;
    localparam int N_OUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [71:0] in_vec;
    logic        cfg_we;
    logic        cfg_sel;
    logic [5:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        busy0, done0, busy1, done1;
    logic [63:0] out0, out1;

    always #5 clk = ~clk;

    fc_layer_seq #(.RELU(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy0), .done(done0), .out_vec(out0)
    );

    fc_layer_seq #(.RELU(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_vec(in_vec),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .busy(busy1), .done(done1), .out_vec(out1)
    );

    int checks   = 0;
    int failures = 0;

    // Reference state: weights, biases, inputs as plain integers
    int mw [N_IN*N_OUT];
    int mb [N_OUT];
    int mi [N_IN];

    typedef struct packed {
        logic [71:0] in_v;
        logic [1:0]  wkind;   // 0: all ones, 1: 2 on diagonal, 2: all 127
        logic [63:0] bias;
        logic [63:0] exp0;
        logic [63:0] exp1;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int model(input int j, input bit relu);
        longint s;
        s = mb[j];
        for (int i = 0; i < N_IN; i++) s += longint'(mi[i]) * longint'(mw[j*N_IN+i]);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        if (relu && s < 0) s = 0;
        return int'(s);
    endfunction

    task automatic cfg_write(input bit sel, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = 6'(addr);
        cfg_data = 16'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic load_all();
        for (int k = 0; k < N_IN*N_OUT; k++) cfg_write(1'b0, k, mw[k]);
        for (int j = 0; j < N_OUT; j++) cfg_write(1'b1, j, mb[j]);
    endtask

    task automatic drive_in();
        for (int i = 0; i < N_IN; i++) in_vec[i*8 +: 8] = 8'(mi[i]);
    endtask

    task automatic check_outs(input string name);
        for (int j = 0; j < N_OUT; j++) begin
            check($sformatf("%s.out0[%0d]", name, j), s16(out0[j*16 +: 16]), model(j, 1'b0));
            check($sformatf("%s.out1[%0d]", name, j), s16(out1[j*16 +: 16]), model(j, 1'b1));
        end
    endtask

    // One full run. ev_start / ev_cfg: cycle index after E0 at which a stray
    // start pulse or a busy-time weight-0 write is driven (-1 = none).
    // wr_bias: write bias[0]=100 in the same cycle as the accepted start.
    task automatic run(input string name, input int ev_start, input int ev_cfg, input bit wr_bias);
        int busy_cnt, done_cnt, done_at, done1_cnt;
        start = 1'b1;
        drive_in();
        if (wr_bias) begin
            cfg_we = 1'b1; cfg_sel = 1'b1; cfg_addr = 6'd0; cfg_data = 16'd100;
            mb[0] = 100;
        end
        @(negedge clk);                       // edge E0 has passed
        start     = 1'b0;
        cfg_we    = 1'b0;
        in_vec    = ~in_vec;                  // latched copy must be used
        busy_cnt  = 0; done_cnt = 0; done_at = -1; done1_cnt = 0;
        for (int c = 0; c < 48; c++) begin
            if (busy0) busy_cnt++;
            if (done1) done1_cnt++;
            if (done0) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            start = (c == ev_start);
            if (c == ev_cfg) begin
                cfg_we = 1'b1; cfg_sel = 1'b0; cfg_addr = 6'd0; cfg_data = 16'd5;
            end else begin
                cfg_we = 1'b0;
            end
            @(negedge clk);
        end
        start  = 1'b0;
        cfg_we = 1'b0;
        check({name, ".busy_cycles"}, busy_cnt, 41);
        check({name, ".done_count"}, done_cnt, 1);
        check({name, ".done_cycle"}, done_at, 40);
        check({name, ".done1_count"}, done1_cnt, 1);
        check_outs(name);
    endtask

    task automatic set_ones();
        for (int k = 0; k < N_IN*N_OUT; k++) mw[k] = 1;
        for (int j = 0; j < N_OUT; j++) mb[j] = 0;
        for (int i = 0; i < N_IN; i++) mi[i] = i + 1;
    endtask

    initial begin
        int dcnt;

        tbl[0] = '{in_v: {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, wkind: 2'd0,
                   bias: 64'h0, exp0: {4{16'd45}}, exp1: {4{16'd45}}};
        tbl[1] = '{in_v: {{5{8'd0}}, 8'd40, 8'd30, 8'd20, 8'd10}, wkind: 2'd1,
                   bias: {16'hFFFD, 16'hFFFE, 16'hFFFF, 16'h0000},
                   exp0: {16'd77, 16'd58, 16'd39, 16'd20}, exp1: {16'd77, 16'd58, 16'd39, 16'd20}};
        tbl[2] = '{in_v: {9{8'd127}}, wkind: 2'd2,
                   bias: {4{16'h7FFF}}, exp0: {4{16'h7FFF}}, exp1: {4{16'h7FFF}}};
        tbl[3] = '{in_v: {9{8'h80}}, wkind: 2'd2,
                   bias: {4{16'h8000}}, exp0: {4{16'h8000}}, exp1: 64'h0};

        rst = 1'b1; start = 1'b0; in_vec = '0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.busy", int'(busy0), 0);
        check("reset.done", int'(done0), 0);
        for (int j = 0; j < N_OUT; j++) check($sformatf("reset.out[%0d]", j), s16(out0[j*16 +: 16]), 0);

        // Directed table
        for (int t = 0; t < 4; t++) begin
            for (int j = 0; j < N_OUT; j++) begin
                for (int i = 0; i < N_IN; i++) begin
                    case (tbl[t].wkind)
                        2'd0:    mw[j*N_IN+i] = 1;
                        2'd1:    mw[j*N_IN+i] = (i == j) ? 2 : 0;
                        default: mw[j*N_IN+i] = 127;
                    endcase
                end
                mb[j] = s16(tbl[t].bias[j*16 +: 16]);
            end
            for (int i = 0; i < N_IN; i++) mi[i] = int'($signed(tbl[t].in_v[i*8 +: 8]));
            load_all();
            run($sformatf("tbl%0d", t), -1, -1, 1'b0);
            for (int j = 0; j < N_OUT; j++) begin
                check($sformatf("tbl%0d.exp0[%0d]", t, j), s16(out0[j*16 +: 16]), s16(tbl[t].exp0[j*16 +: 16]));
                check($sformatf("tbl%0d.exp1[%0d]", t, j), s16(out1[j*16 +: 16]), s16(tbl[t].exp1[j*16 +: 16]));
            end
        end

        // Randomized runs against the model
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N_IN*N_OUT; k++) mw[k] = int'($urandom_range(0, 255)) - 128;
            for (int j = 0; j < N_OUT; j++)
                mb[j] = (r % 2 == 0) ? int'($urandom_range(0, 65535)) - 32768
                                     : int'($urandom_range(0, 2000)) - 1000;
            for (int i = 0; i < N_IN; i++) mi[i] = int'($urandom_range(0, 255)) - 128;
            load_all();
            run($sformatf("rand%0d", r), -1, -1, r == 5);
        end

        // Stray start and busy-time config write are ignored
        set_ones();
        load_all();
        run("ignored", 9, 5, 1'b0);
        run("readback", -1, -1, 1'b0);

        // Out-of-range addresses change nothing
        cfg_write(1'b0, 36, 7);
        cfg_write(1'b1, 4, 9);
        run("oor", -1, -1, 1'b0);

        // Reset mid-run
        start = 1'b1;
        drive_in();
        @(negedge clk);
        start = 1'b0;
        dcnt  = 0;
        for (int c = 0; c < 30; c++) begin
            if (done0 || done1) dcnt++;
            if (c == 20) begin
                check("midrst.busy", int'(busy0), 0);
                for (int j = 0; j < N_OUT; j++)
                    check($sformatf("midrst.out[%0d]", j), s16(out0[j*16 +: 16]), 0);
            end
            rst = (c == 19);
            @(negedge clk);
        end
        rst = 1'b0;
        check("midrst.no_done", dcnt, 0);
        for (int k = 0; k < N_IN*N_OUT; k++) mw[k] = 0;
        for (int j = 0; j < N_OUT; j++) mb[j] = 5000;
        cfg_write(1'b1, 0, 5000);
        cfg_write(1'b1, 1, 5000);
        cfg_write(1'b1, 2, 5000);
        cfg_write(1'b1, 3, 5000);
        run("postrst_zero_w", -1, -1, 1'b0);
        set_ones();
        load_all();
        run("postrst_ones", -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
